// File: rtl/mc_pkg.sv
// Shared state encoding, PC-source codes and defaults for the multi-cycle sequencer.
package mc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_MEM    = 3'd4,
    ST_WB     = 3'd5,
    ST_FAULT  = 3'd6
  } mc_state_e;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;
  localparam logic [1:0] PC_SRC_RS     = 2'b11;

  localparam int MEM_TIMEOUT_DEF = 16;

  typedef struct packed {
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } dec_latch_t;

  // Where an instruction goes once it has finished: run is only looked at here.
  function automatic mc_state_e boundary_state(input logic run);
    return run ? ST_FETCH : ST_IDLE;
  endfunction

endpackage

// File: rtl/mc_seq_ctrl_if.sv
// Handshake and control bundle between the sequencer (master) and the shared datapath (slave).
interface mc_seq_ctrl_if;

  logic       run;
  logic       dec_memread;
  logic       dec_memwrite;
  logic       dec_regwrite;
  logic       dec_memtoreg;
  logic       dec_j;
  logic       dec_jr;
  logic       dec_branch;
  logic       branch_taken;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       iord;
  logic       ir_write;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       exec_en;
  logic       reg_write_en;
  logic       wb_sel;
  logic [2:0] state;
  logic       fault;

  modport master (
    input  run, dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg,
           dec_j, dec_jr, dec_branch, branch_taken, mem_ready,
    output mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           exec_en, reg_write_en, wb_sel, state, fault
  );

  modport slave (
    output run, dec_memread, dec_memwrite, dec_regwrite, dec_memtoreg,
           dec_j, dec_jr, dec_branch, branch_taken, mem_ready,
    input  mem_req, mem_we, iord, ir_write, pc_write, pc_src,
           exec_en, reg_write_en, wb_sel, state, fault
  );

endinterface

// File: rtl/mc_mem_watchdog.sv
// Memory-stall watchdog: counts unacknowledged request cycles and raises a sticky fault.
module mc_mem_watchdog import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic reset,
  input  logic waiting,
  input  logic mem_ready,
  output logic trip,
  output logic fault
);

  localparam bit              WD_EN = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] LAST  = TO_W'(MEM_TIMEOUT - 1);

  logic [TO_W-1:0] cnt_q, cnt_d;
  logic            fault_q, fault_d;

  // Trip on the MEM_TIMEOUT-th stalled cycle; an acknowledge in that same cycle wins.
  always_comb begin
    trip    = 1'b0;
    cnt_d   = '0;
    fault_d = fault_q;
    if (WD_EN && waiting && !mem_ready) begin
      if (cnt_q == LAST) begin
        trip    = 1'b1;
        fault_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + TO_W'(1);
      end
    end else begin
      cnt_d = '0;
    end
  end

  // Counter and sticky fault flop; only reset clears the fault.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/mc_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the shared MIPS datapath.
// Define MC_SEQ_PERF_CNT_EN to add the cycle_cnt/instr_cnt performance counters.
module mc_seq_ctrl import mc_pkg::*; #(
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF,
  parameter int TO_W        = 5
`ifdef MC_SEQ_PERF_CNT_EN
  , parameter int CNT_W     = 32
`endif
) (
  input  logic               clk,
  input  logic               reset,
  mc_seq_ctrl_if.master      bus
`ifdef MC_SEQ_PERF_CNT_EN
  , output logic [CNT_W-1:0] cycle_cnt
  , output logic [CNT_W-1:0] instr_cnt
`endif
);

  mc_state_e  state_q, state_d;
  dec_latch_t lat_q, lat_d;
  logic       waiting;
  logic       trip;
  logic       fault_s;

  assign waiting = (state_q == ST_FETCH) || (state_q == ST_MEM);

  mc_mem_watchdog #(
    .MEM_TIMEOUT (MEM_TIMEOUT),
    .TO_W        (TO_W)
  ) u_wdog (
    .clk       (clk),
    .reset     (reset),
    .waiting   (waiting),
    .mem_ready (bus.mem_ready),
    .trip      (trip),
    .fault     (fault_s)
  );

  // Next-state and decode-latch logic.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.run) state_d = ST_FETCH;
        else         state_d = ST_IDLE;
      end
      ST_FETCH: begin
        if (trip)               state_d = ST_FAULT;
        else if (bus.mem_ready) state_d = ST_DECODE;
        else                    state_d = ST_FETCH;
      end
      ST_DECODE: begin
        lat_d.memread  = bus.dec_memread;
        lat_d.memwrite = bus.dec_memwrite;
        lat_d.regwrite = bus.dec_regwrite;
        lat_d.memtoreg = bus.dec_memtoreg;
        if (bus.dec_j || bus.dec_jr) state_d = boundary_state(bus.run);
        else                         state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (bus.dec_branch)                         state_d = boundary_state(bus.run);
        else if (lat_q.memread || lat_q.memwrite)   state_d = ST_MEM;
        else if (lat_q.regwrite)                    state_d = ST_WB;
        else                                        state_d = boundary_state(bus.run);
      end
      ST_MEM: begin
        if (trip)               state_d = ST_FAULT;
        else if (!bus.mem_ready) state_d = ST_MEM;
        else if (lat_q.memread) state_d = ST_WB;
        else                    state_d = boundary_state(bus.run);
      end
      ST_WB: begin
        state_d = boundary_state(bus.run);
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and latched decode bits.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Datapath controls, decoded from registered state; handshake strobes gated by mem_ready.
  always_comb begin
    bus.mem_req      = 1'b0;
    bus.mem_we       = 1'b0;
    bus.iord         = 1'b0;
    bus.ir_write     = 1'b0;
    bus.pc_write     = 1'b0;
    bus.pc_src       = PC_SRC_SEQ;
    bus.exec_en      = 1'b0;
    bus.reg_write_en = 1'b0;
    bus.wb_sel       = 1'b0;
    case (state_q)
      ST_FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        bus.pc_src   = PC_SRC_SEQ;
      end
      ST_DECODE: begin
        if (bus.dec_j) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_JUMP;
        end else if (bus.dec_jr) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = PC_SRC_RS;
        end else begin
          bus.pc_write = 1'b0;
          bus.pc_src   = PC_SRC_SEQ;
        end
      end
      ST_EXEC: begin
        bus.exec_en = 1'b1;
        if (bus.dec_branch) begin
          bus.pc_write = bus.branch_taken;
          bus.pc_src   = PC_SRC_BRANCH;
        end else begin
          bus.pc_write = 1'b0;
          bus.pc_src   = PC_SRC_SEQ;
        end
      end
      ST_MEM: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        bus.mem_we  = lat_q.memwrite;
      end
      ST_WB: begin
        bus.reg_write_en = 1'b1;
        bus.wb_sel       = lat_q.memtoreg;
      end
      default: begin
        bus.mem_req = 1'b0;
      end
    endcase
    bus.state = state_q;
    bus.fault = fault_s;
  end

`ifdef MC_SEQ_PERF_CNT_EN
  logic             instr_done;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  // Marks the last cycle of every instruction (the boundary).
  always_comb begin
    instr_done = 1'b0;
    case (state_q)
      ST_DECODE: instr_done = bus.dec_j | bus.dec_jr;
      ST_EXEC:   instr_done = bus.dec_branch |
                              ~(lat_q.memread | lat_q.memwrite | lat_q.regwrite);
      ST_MEM:    instr_done = bus.mem_ready & ~lat_q.memread;
      ST_WB:     instr_done = 1'b1;
      default:   instr_done = 1'b0;
    endcase
  end

  // Counter increments; both wrap naturally at 2^CNT_W.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (state_q != ST_IDLE && state_q != ST_FAULT) cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    else                                           cycle_cnt_d = cycle_cnt_q;
    if (instr_done) instr_cnt_d = instr_cnt_q + CNT_W'(1);
    else            instr_cnt_d = instr_cnt_q;
  end

  // Performance counter registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_mc_seq_ctrl.sv
// Self-checking bench for mc_seq_ctrl: instructions are expanded into per-cycle expected traces.
module tb_mc_seq_ctrl;
  import mc_pkg::*;

  localparam int TO = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mc_seq_ctrl_if bus_if();

`ifdef MC_SEQ_PERF_CNT_EN
  logic [31:0] cycle_cnt, instr_cnt;
`endif

  mc_seq_ctrl #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.master)
`ifdef MC_SEQ_PERF_CNT_EN
    , .cycle_cnt (cycle_cnt)
    , .instr_cnt (instr_cnt)
`endif
  );

  typedef enum int {K_LOAD, K_STORE, K_ALUW, K_ALUN, K_BR, K_J, K_JR, K_JJR} kind_e;

  // mid_run / taken: 0 or 1 force the value, 2 = random; rst_at < 0 means no reset.
  typedef struct {
    kind_e kind; int fwait; int mwait; int mid_run; logic run_end;
    int rst_at; int idle_n; int taken;
  } instr_t;

  typedef struct {
    logic rst; logic run; logic [6:0] dec; logic taken; logic ready; logic bnd;
    logic [13:0] exp;
  } step_t;

  step_t  steps[$];
  instr_t dir[$];
  bit     in_idle;
  int     cur_mid;
  int     checks = 0;
  int     errors = 0;

  // Output vector order: {state, mem_req, mem_we, iord, ir_write, pc_write, pc_src, exec_en, reg_write_en, wb_sel, fault}
  function automatic logic [13:0] mk(input logic [2:0] st, input logic req, we, iord, irw, pcw,
                                     input logic [1:0] src, input logic exe, rwe, wbs, flt);
    return {st, req, we, iord, irw, pcw, src, exe, rwe, wbs, flt};
  endfunction

  function automatic logic [13:0] obs();
    return {bus_if.state, bus_if.mem_req, bus_if.mem_we, bus_if.iord, bus_if.ir_write,
            bus_if.pc_write, bus_if.pc_src, bus_if.exec_en, bus_if.reg_write_en,
            bus_if.wb_sel, bus_if.fault};
  endfunction

  function automatic logic r1();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [6:0] r7();
    return 7'($urandom);
  endfunction

  function automatic logic mrun();
    return (cur_mid == 2) ? r1() : (cur_mid == 1);
  endfunction

  task automatic push(input logic rst, input logic run, input logic [6:0] dec,
                      input logic taken, input logic ready, input logic [13:0] e);
    step_t s;
    s.rst = rst; s.run = run; s.dec = dec; s.taken = taken; s.ready = ready;
    s.bnd = 1'b0; s.exp = e;
    steps.push_back(s);
  endtask

  task automatic close(input logic run_end);
    steps[steps.size()-1].run = run_end;
    steps[steps.size()-1].bnd = 1'b1;
    in_idle = !run_end;
  endtask

  task automatic fault_tail();
    for (int i = 0; i < 3; i++)
      push(1'b0, r1(), r7(), r1(), r1(), mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    push(1'b1, r1(), r7(), r1(), r1(), mk(3'd6, 0, 0, 0, 0, 0, 2'b00, 0, 0, 0, 1));
    push(1'b0, 1'b0, r7(), r1(), r1(), 14'd0);
    in_idle = 1'b1;
  endtask

  // Expand one instruction into the cycle trace the sequencer must produce.
  task automatic gen_instr(input instr_t t);
    logic mr, mw, rw, mtr, j, jr, br, tk;
    logic [6:0] d;
    mr = 1'b0; mw = 1'b0; rw = 1'b0; mtr = r1(); j = 1'b0; jr = 1'b0; br = 1'b0;
    case (t.kind)
      K_LOAD:  begin mr = 1'b1; rw = 1'b1; mtr = 1'b1; end
      K_STORE: mw = 1'b1;
      K_ALUW:  rw = 1'b1;
      K_BR:    begin br = 1'b1; mr = r1(); mw = r1(); rw = r1(); end
      K_J:     begin j = 1'b1; jr = r1(); br = r1(); mr = r1(); mw = r1(); rw = r1(); end
      K_JR:    begin jr = 1'b1; br = r1(); mr = r1(); mw = r1(); rw = r1(); end
      K_JJR:   begin j = 1'b1; jr = 1'b1; end
      default: ;
    endcase
    d = {mr, mw, rw, mtr, j, jr, br};
    cur_mid = t.mid_run;
    if (in_idle) begin
      for (int i = 0; i < t.idle_n; i++) push(1'b0, 1'b0, r7(), r1(), r1(), 14'd0);
      push(1'b0, 1'b1, r7(), r1(), r1(), 14'd0);
    end
    in_idle = 1'b0;
    for (int i = 0; i < t.fwait && i < TO; i++) begin
      if (i == t.rst_at) begin
        push(1'b1, mrun(), r7(), r1(), 1'b1, mk(3'd1, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0));
        push(1'b0, 1'b0, r7(), r1(), 1'b1, 14'd0);
        in_idle = 1'b1;
        return;
      end
      push(1'b0, mrun(), r7(), r1(), 1'b0, mk(3'd1, 1, 0, 0, 0, 0, 2'b00, 0, 0, 0, 0));
    end
    if (t.fwait >= TO) begin fault_tail(); return; end
    push(1'b0, mrun(), r7(), r1(), 1'b1, mk(3'd1, 1, 0, 0, 1, 1, 2'b00, 0, 0, 0, 0));
    push(1'b0, mrun(), d, r1(), r1(),
         mk(3'd2, 0, 0, 0, 0, j | jr, j ? 2'b10 : (jr ? 2'b11 : 2'b00), 0, 0, 0, 0));
    if (j || jr) begin close(t.run_end); return; end
    tk = (t.taken == 2) ? r1() : (t.taken == 1);
    push(1'b0, mrun(), d, tk, r1(), mk(3'd3, 0, 0, 0, 0, br & tk, br ? 2'b01 : 2'b00, 1, 0, 0, 0));
    if (br) begin close(t.run_end); return; end
    if (mr || mw) begin
      for (int i = 0; i < t.mwait && i < TO; i++)
        push(1'b0, mrun(), d, r1(), 1'b0, mk(3'd4, 1, mw, 1, 0, 0, 2'b00, 0, 0, 0, 0));
      if (t.mwait >= TO) begin fault_tail(); return; end
      push(1'b0, mrun(), d, r1(), 1'b1, mk(3'd4, 1, mw, 1, 0, 0, 2'b00, 0, 0, 0, 0));
      if (!mr) begin close(t.run_end); return; end
    end else if (!rw) begin
      close(t.run_end);
      return;
    end
    push(1'b0, mrun(), d, r1(), r1(), mk(3'd5, 0, 0, 0, 0, 0, 2'b00, 0, 1, mtr, 0));
    close(t.run_end);
  endtask

  // Drive each recorded cycle after the clock edge and compare the settled outputs.
  task automatic apply_all();
    logic [13:0] got;
    int exp_cyc = 0;
    int exp_ins = 0;
    for (int k = 0; k < steps.size(); k++) begin
      @(posedge clk);
      #1;
      reset               = steps[k].rst;
      bus_if.run          = steps[k].run;
      {bus_if.dec_memread, bus_if.dec_memwrite, bus_if.dec_regwrite, bus_if.dec_memtoreg,
       bus_if.dec_j, bus_if.dec_jr, bus_if.dec_branch} = steps[k].dec;
      bus_if.branch_taken = steps[k].taken;
      bus_if.mem_ready    = steps[k].ready;
      #1;
      got = obs();
      checks++;
      if (got !== steps[k].exp) begin
        errors++;
        $display("FAIL step[%0d] outputs{st,req,we,iord,irw,pcw,src,exe,rwe,wbs,flt} got %b required %b",
                 k, got, steps[k].exp);
      end
`ifdef MC_SEQ_PERF_CNT_EN
      checks++;
      if (cycle_cnt !== 32'(exp_cyc) || instr_cnt !== 32'(exp_ins)) begin
        errors++;
        $display("FAIL perf[%0d] got cyc=%0d ins=%0d required cyc=%0d ins=%0d",
                 k, cycle_cnt, instr_cnt, exp_cyc, exp_ins);
      end
      if (steps[k].rst) begin
        exp_cyc = 0;
        exp_ins = 0;
      end else begin
        if (steps[k].exp[13:11] != 3'd0 && steps[k].exp[13:11] != 3'd6) exp_cyc++;
        if (steps[k].bnd) exp_ins++;
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b1;
    bus_if.run = 1'b0; bus_if.dec_memread = 1'b0; bus_if.dec_memwrite = 1'b0;
    bus_if.dec_regwrite = 1'b0; bus_if.dec_memtoreg = 1'b0; bus_if.dec_j = 1'b0;
    bus_if.dec_jr = 1'b0; bus_if.dec_branch = 1'b0; bus_if.branch_taken = 1'b0;
    bus_if.mem_ready = 1'b0;
    in_idle = 1'b1;

    // kind, fwait, mwait, mid_run, run_end, rst_at, idle_n, taken
    dir.push_back('{K_LOAD,  0, 0, 1, 1'b1, -1, 2, 2});
    dir.push_back('{K_STORE, 0, 3, 1, 1'b1, -1, 0, 2});
    dir.push_back('{K_BR,    1, 0, 1, 1'b1, -1, 0, 1});
    dir.push_back('{K_BR,    0, 0, 1, 1'b1, -1, 0, 0});
    dir.push_back('{K_JJR,   0, 0, 1, 1'b1, -1, 0, 2});
    dir.push_back('{K_J,     2, 0, 0, 1'b1, -1, 0, 2});
    dir.push_back('{K_JR,    0, 0, 2, 1'b1, -1, 0, 2});
    dir.push_back('{K_ALUW,  0, 0, 0, 1'b0, -1, 0, 2});
    dir.push_back('{K_ALUN,  3, 0, 2, 1'b1, -1, 3, 2});
    dir.push_back('{K_LOAD,  4, 0, 1, 1'b1, -1, 1, 2});
    dir.push_back('{K_LOAD,  1, 5, 1, 1'b1, -1, 0, 2});
    dir.push_back('{K_STORE, 3, 0, 1, 1'b1,  2, 0, 2});
    dir.push_back('{K_LOAD,  2, 2, 2, 1'b0, -1, 1, 2});
    foreach (dir[i]) gen_instr(dir[i]);

    for (int n = 0; n < 150; n++) begin
      instr_t t;
      t.kind    = kind_e'($urandom_range(0, 7));
      t.fwait   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
      t.mwait   = ($urandom_range(0, 19) == 0) ? int'($urandom_range(4, 5)) : int'($urandom_range(0, 3));
      t.mid_run = 2;
      t.run_end = ($urandom_range(0, 3) != 0);
      t.rst_at  = ($urandom_range(0, 29) == 0 && t.fwait > 0) ? 0 : -1;
      t.idle_n  = int'($urandom_range(0, 2));
      t.taken   = 2;
      gen_instr(t);
    end

    repeat (3) @(posedge clk);
    apply_all();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
